// File: rtl/relatorio_serial_seq.sv
// rtl/relatorio_serial_seq.sv - seq_a/seq_b event counters with queued serial frame reporting
module relatorio_serial_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seq_a,
   input  logic             seq_b,
   output logic             tx,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] count_a,
   output logic [CNT_W-1:0] count_b
);

   localparam int DW  = 2 + CNT_W;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int BCW = $clog2(DW);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, next_state;
   logic [DW-1:0]    mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0] frame_num;
   logic [DW-1:0]    shreg;
   logic             par_r;
   logic [BCW-1:0]   bit_cnt;

   logic            fifo_empty, fifo_full, evt, push, pop, drop, last_bit, tx_d;
   logic [DW-1:0]   rd_data;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign evt        = seq_a | seq_b;
   assign rd_data    = mem[rd_ptr[AW-1:0]];
   assign last_bit   = (bit_cnt == BCW'(DW - 1));
   assign busy       = (state != IDLE) | ~fifo_empty;

   // A pop frees a slot on the same edge, so a push into a full FIFO still lands then
   assign push = evt & (~fifo_full | pop);
   assign drop = evt & fifo_full & ~pop;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!fifo_empty) next_state = START;
         START:   next_state = DATA;
         DATA:    if (last_bit) next_state = PARITY;
         PARITY:  next_state = STOP;
         STOP:    next_state = fifo_empty ? IDLE : START;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      pop  = 1'b0;
      tx_d = 1'b1;
      case (state)
         IDLE, STOP: begin
            pop  = ~fifo_empty;
            tx_d = fifo_empty;
         end
         START:   tx_d = shreg[0];
         DATA:    tx_d = last_bit ? par_r : shreg[0];
         PARITY:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {frame_num, seq_b, seq_a};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         frame_num <= '0;
         count_a   <= '0;
         count_b   <= '0;
         overflow  <= 1'b0;
         shreg     <= '0;
         par_r     <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         state <= next_state;
         tx    <= tx_d;
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + (AW+1)'(1);
            shreg   <= rd_data;
            par_r   <= ^rd_data;
            bit_cnt <= '0;
         end else if (state == START || state == DATA) begin
            shreg <= {1'b0, shreg[DW-1:1]};
            if (state == DATA) bit_cnt <= bit_cnt + BCW'(1);
         end
         // Frame number advances even on a dropped push so the receiver sees the gap
         if (evt) frame_num <= frame_num + CNT_W'(1);
         if (seq_a) count_a <= count_a + CNT_W'(1);
         if (seq_b) count_b <= count_b + CNT_W'(1);
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_relatorio_serial_seq.sv
// tb/tb_relatorio_serial_seq.sv - scoreboard bench for relatorio_serial_seq
module tb_relatorio_serial_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       seq_a = 1'b0;
   logic       seq_b = 1'b0;
   logic       tx, busy, overflow;
   logic [3:0] count_a, count_b;

   relatorio_serial_seq #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .seq_a(seq_a), .seq_b(seq_b),
      .tx(tx), .busy(busy), .overflow(overflow),
      .count_a(count_a), .count_b(count_b)
   );

   always #5 clk = ~clk;

   int         compared = 0;
   int         mismatched = 0;
   int         cyc = 0;
   logic [8:0] exp_q[$];
   int         start_q[$];
   logic [3:0] m_fnum = 4'd0;

   always @(posedge clk) cyc++;

   function automatic logic [8:0] mk_frame(input logic [1:0] t, input logic [3:0] n);
      logic [8:0] f;
      f[0]   = 1'b0;
      f[1]   = t[0];
      f[2]   = t[1];
      f[6:3] = n;
      f[7]   = t[0] ^ t[1] ^ n[0] ^ n[1] ^ n[2] ^ n[3];
      f[8]   = 1'b1;
      return f;
   endfunction

   // Frame receiver: collects 9 bits after each falling tx edge and checks against the queue
   logic       in_frame = 1'b0;
   logic [8:0] rx;
   logic [8:0] rx_exp;
   int         idx;
   always @(negedge clk) begin
      if (reset) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (tx === 1'b0) begin
            in_frame = 1'b1;
            rx = '0;
            idx = 1;
            start_q.push_back(cyc);
         end
      end else begin
         rx[idx] = tx;
         idx++;
         if (idx == 9) begin
            in_frame = 1'b0;
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL frame_unexpected got=%b required=none", rx);
            end else begin
               rx_exp = exp_q.pop_front();
               if (rx !== rx_exp) begin
                  mismatched++;
                  $display("FAIL frame got=%b required=%b", rx, rx_exp);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      seq_a = 1'b0;
      seq_b = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      start_q.delete();
      m_fnum = 4'd0;
   endtask

   task automatic pulse(input logic a, input logic b);
      @(negedge clk);
      seq_a = a;
      seq_b = b;
      exp_q.push_back(mk_frame({b, a}, m_fnum));
      m_fnum++;
      @(negedge clk);
      seq_a = 1'b0;
      seq_b = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while ((busy || exp_q.size() != 0 || in_frame) && n < max) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n >= max) begin
         mismatched++;
         $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      compared += 5;
      if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx got=%b required=1", tx); end
      if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b required=0", busy); end
      if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow got=%b required=0", overflow); end
      if (count_a !== 4'd0) begin mismatched++; $display("FAIL reset_count_a got=%0d required=0", count_a); end
      if (count_b !== 4'd0) begin mismatched++; $display("FAIL reset_count_b got=%0d required=0", count_b); end
   endtask

   task automatic test_single_a();
      logic [8:0] bits;
      bits = 9'b110000010;
      do_reset();
      @(negedge clk);
      seq_a = 1'b1;
      exp_q.push_back(bits);
      m_fnum++;
      @(negedge clk);
      seq_a = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j <= 9) begin
            compared++;
            if (tx !== bits[j-1]) begin
               mismatched++;
               $display("FAIL single_a_tx bit=%0d got=%b required=%b", j - 1, tx, bits[j-1]);
            end
         end
         if (j == 9) begin
            compared++;
            if (busy !== 1'b1) begin mismatched++; $display("FAIL single_a_busy_stop got=%b required=1", busy); end
         end
         if (j == 10) begin
            compared++;
            if (busy !== 1'b0) begin mismatched++; $display("FAIL single_a_busy_idle got=%b required=0", busy); end
         end
      end
      wait_idle("single_a", 20);
      compared++;
      if (count_a !== 4'd1) begin mismatched++; $display("FAIL single_a_count got=%0d required=1", count_a); end
   endtask

   task automatic test_single_b();
      @(negedge clk);
      seq_b = 1'b1;
      exp_q.push_back(9'b100001100);
      m_fnum++;
      @(negedge clk);
      seq_b = 1'b0;
      wait_idle("single_b", 30);
      compared += 2;
      if (count_b !== 4'd1) begin mismatched++; $display("FAIL single_b_count_b got=%0d required=1", count_b); end
      if (count_a !== 4'd1) begin mismatched++; $display("FAIL single_b_count_a got=%0d required=1", count_a); end
   endtask

   task automatic test_both();
      do_reset();
      @(negedge clk);
      seq_a = 1'b1;
      seq_b = 1'b1;
      exp_q.push_back(9'b100000110);
      m_fnum++;
      @(negedge clk);
      seq_a = 1'b0;
      seq_b = 1'b0;
      wait_idle("both", 30);
      compared += 2;
      if (count_a !== 4'd1) begin mismatched++; $display("FAIL both_count_a got=%0d required=1", count_a); end
      if (count_b !== 4'd1) begin mismatched++; $display("FAIL both_count_b got=%0d required=1", count_b); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      seq_a = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk_frame(2'b01, 4'(i)));
      repeat (5) @(negedge clk);
      compared++;
      if (overflow !== 1'b0) begin mismatched++; $display("FAIL b2b_overflow_early got=%b required=0", overflow); end
      @(negedge clk);
      seq_a = 1'b0;
      compared += 2;
      if (overflow !== 1'b1) begin mismatched++; $display("FAIL b2b_overflow got=%b required=1", overflow); end
      if (count_a !== 4'd6) begin mismatched++; $display("FAIL b2b_count_a got=%0d required=6", count_a); end
      wait_idle("b2b", 100);
      compared += 2;
      if (start_q.size() != 5) begin
         mismatched++;
         $display("FAIL b2b_frames got=%0d required=5", start_q.size());
      end
      if (overflow !== 1'b1) begin mismatched++; $display("FAIL b2b_overflow_sticky got=%b required=1", overflow); end
      for (int i = 1; i < start_q.size(); i++) begin
         compared++;
         if (start_q[i] - start_q[i-1] != 9) begin
            mismatched++;
            $display("FAIL b2b_spacing frame=%0d got=%0d required=9", i, start_q[i] - start_q[i-1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int zeros = 0;
      int busy_hi = 0;
      do_reset();
      @(negedge clk);
      seq_a = 1'b1;
      repeat (3) @(negedge clk);
      seq_a = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      compared += 5;
      if (tx !== 1'b1) begin mismatched++; $display("FAIL mid_reset_tx got=%b required=1", tx); end
      if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy got=%b required=0", busy); end
      if (count_a !== 4'd0) begin mismatched++; $display("FAIL mid_reset_count_a got=%0d required=0", count_a); end
      if (overflow !== 1'b0) begin mismatched++; $display("FAIL mid_reset_overflow got=%b required=0", overflow); end
      if (in_frame !== 1'b0) begin mismatched++; $display("FAIL mid_reset_partial got=%b required=0", in_frame); end
      repeat (30) begin
         @(negedge clk);
         if (tx !== 1'b1) zeros++;
         if (busy !== 1'b0) busy_hi++;
      end
      compared += 2;
      if (zeros != 0) begin mismatched++; $display("FAIL mid_reset_quiet_tx got=%0d required=0", zeros); end
      if (busy_hi != 0) begin mismatched++; $display("FAIL mid_reset_quiet_busy got=%0d required=0", busy_hi); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         pulse(1'b1, 1'b0);
         wait_idle("wrap", 40);
      end
      compared++;
      if (count_a !== 4'd1) begin mismatched++; $display("FAIL wrap_count_a got=%0d required=1", count_a); end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_single_b();
      test_both();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
